// File: rtl/axis_pkt_mux_pkg.sv
// Shared types and defaults for the AXI-Stream switch blocks (arbiter, packet mux, demux).
//   DefaultNIn / DefaultDataW : default port count and tdata width used across the switch
//   axis_beat_t               : one stream beat {data, keep, last, id} at the default widths
//   mux_state_t               : packet mux FSM states
package axis_switch_pkg;

    localparam int unsigned DefaultNIn   = 8;
    localparam int unsigned DefaultDataW = 32;
    localparam int unsigned DefaultKeepW = DefaultDataW / 8;
    localparam int unsigned DefaultIdW   = $clog2(DefaultNIn);

    typedef struct packed {
        logic [DefaultDataW-1:0] data;
        logic [DefaultKeepW-1:0] keep;
        logic                    last;
        logic [DefaultIdW-1:0]   id;
    } axis_beat_t;

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } mux_state_t;

endpackage

// File: rtl/axis_pkt_mux_if.sv
// Bundle of all handshake/bus signals around the packet mux.
//   gnt, gnt_id, gnt_vld, gnt_rdy         : grant handshake from the round-robin arbiter
//   s_tdata/tkeep/tlast/tvalid/tready     : N_IN slave streams, packed [N_IN-1:0][...]
//   m_tdata/tkeep/tlast/tid/tvalid/tready : single master stream
// Modports:
//   master : the mux itself (drives gnt_rdy, s_tready and the master stream)
//   slave  : the surrounding environment (arbiter, upstream sources, downstream sink)
interface axis_pkt_mux_if
    import axis_switch_pkg::*;
#(
    parameter int unsigned N_IN   = DefaultNIn,
    parameter int unsigned DATA_W = DefaultDataW
) ();

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned ID_W   = $clog2(N_IN);

    logic [N_IN-1:0]              gnt;
    logic [ID_W-1:0]              gnt_id;
    logic                         gnt_vld;
    logic                         gnt_rdy;

    logic [N_IN-1:0][DATA_W-1:0]  s_tdata;
    logic [N_IN-1:0][KEEP_W-1:0]  s_tkeep;
    logic [N_IN-1:0]              s_tlast;
    logic [N_IN-1:0]              s_tvalid;
    logic [N_IN-1:0]              s_tready;

    logic [DATA_W-1:0]            m_tdata;
    logic [KEEP_W-1:0]            m_tkeep;
    logic                         m_tlast;
    logic [ID_W-1:0]              m_tid;
    logic                         m_tvalid;
    logic                         m_tready;

    modport master (
        input  gnt, gnt_id, gnt_vld,
        output gnt_rdy,
        input  s_tdata, s_tkeep, s_tlast, s_tvalid,
        output s_tready,
        output m_tdata, m_tkeep, m_tlast, m_tid, m_tvalid,
        input  m_tready
    );

    modport slave (
        output gnt, gnt_id, gnt_vld,
        input  gnt_rdy,
        output s_tdata, s_tkeep, s_tlast, s_tvalid,
        input  s_tready,
        input  m_tdata, m_tkeep, m_tlast, m_tid, m_tvalid,
        output m_tready
    );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry register slice for stream beats.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   in_beat_i/in_vld_i/in_rdy_o   : upstream side; in_rdy_o is a flop (low only while spare is full)
//   out_beat_o/out_vld_o/out_rdy_i: downstream side; all outputs registered, held while stalled
module axis_skid_buf
    import axis_switch_pkg::*;
#(
    parameter type beat_t = axis_beat_t
) (
    input  logic  clk,
    input  logic  reset_n,
    input  beat_t in_beat_i,
    input  logic  in_vld_i,
    output logic  in_rdy_o,
    output beat_t out_beat_o,
    output logic  out_vld_o,
    input  logic  out_rdy_i
);

    beat_t out_q, out_d;
    beat_t spare_q, spare_d;
    logic  out_vld_q, out_vld_d;
    logic  spare_vld_q, spare_vld_d;
    logic  in_fire;
    logic  out_free;

    always_comb begin
        in_fire     = in_vld_i & ~spare_vld_q;
        out_free    = ~out_vld_q | out_rdy_i;
        out_d       = out_q;
        out_vld_d   = out_vld_q;
        spare_d     = spare_q;
        spare_vld_d = spare_vld_q;
        if (out_free) begin
            // Spare holds the older beat; while it is full no new beat is accepted.
            if (spare_vld_q) begin
                out_d       = spare_q;
                out_vld_d   = 1'b1;
                spare_vld_d = 1'b0;
            end else if (in_fire) begin
                out_d     = in_beat_i;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            spare_d     = in_beat_i;
            spare_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            spare_q     <= '0;
            spare_vld_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            spare_q     <= spare_d;
            spare_vld_q <= spare_vld_d;
        end
    end

    assign in_rdy_o   = ~spare_vld_q;
    assign out_beat_o = out_q;
    assign out_vld_o  = out_vld_q;

endmodule

// File: rtl/axis_pkt_mux.sv
// Packet mux of the AXI-Stream switch: accepts a grant, locks onto the granted slave port until
// its tlast beat is taken, and forwards the packet through a 2-entry skid buffer.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : grant handshake, N_IN slave streams and the master stream (master modport)
//   busy_o       : high while a packet is locked
module axis_pkt_mux
    import axis_switch_pkg::*;
#(
    parameter int unsigned N_IN   = DefaultNIn,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic                  clk,
    input  logic                  reset_n,
    axis_pkt_mux_if.master        bus,
    output logic                  busy_o
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned ID_W   = $clog2(N_IN);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [ID_W-1:0]   id;
    } beat_t;

    mux_state_t      state_q, state_d;
    logic [ID_W-1:0] sel_q, sel_d;

    beat_t in_beat;
    beat_t m_beat;
    logic  in_vld;
    logic  in_fire;
    logic  skid_in_rdy;
    logic  m_vld;

    // Selected port's beat; id carries the source index alongside the data.
    always_comb begin
        in_beat.data = bus.s_tdata[sel_q];
        in_beat.keep = bus.s_tkeep[sel_q];
        in_beat.last = bus.s_tlast[sel_q];
        in_beat.id   = sel_q;
        in_vld       = (state_q == StLock) & bus.s_tvalid[sel_q];
        in_fire      = in_vld & skid_in_rdy;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                // Out-of-range ids are consumed but ignored.
                if (bus.gnt_vld && (32'(bus.gnt_id) < N_IN)) begin
                    sel_d   = bus.gnt_id;
                    state_d = StLock;
                end
            end
            StLock: begin
                if (in_fire && in_beat.last) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        bus.gnt_rdy  = (state_q == StIdle);
        busy_o       = (state_q == StLock);
        bus.s_tready = '0;
        if (state_q == StLock) begin
            bus.s_tready[sel_q] = skid_in_rdy;
        end
    end

    axis_skid_buf #(
        .beat_t (beat_t)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_beat_i  (in_beat),
        .in_vld_i   (in_vld),
        .in_rdy_o   (skid_in_rdy),
        .out_beat_o (m_beat),
        .out_vld_o  (m_vld),
        .out_rdy_i  (bus.m_tready)
    );

    assign bus.m_tdata  = m_beat.data;
    assign bus.m_tkeep  = m_beat.keep;
    assign bus.m_tlast  = m_beat.last;
    assign bus.m_tid    = m_beat.id;
    assign bus.m_tvalid = m_vld;

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset_n)
        bus.gnt_vld |-> ($onehot(bus.gnt) && bus.gnt[bus.gnt_id]));

    a_tready_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(bus.s_tready));

    a_m_stable : assert property (@(posedge clk) disable iff (!reset_n)
        (bus.m_tvalid && !bus.m_tready) |=>
            (bus.m_tvalid && $stable({bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.m_tid})));

endmodule

// File: tb/tb_axis_pkt_mux.sv
// Self-checking bench for axis_pkt_mux: packets are generated up front into an expected queue
// (grant order, id = source port) and the observed master-stream beats are compared against it.
module tb_axis_pkt_mux;
    import axis_switch_pkg::*;

    localparam int unsigned N_IN   = DefaultNIn;
    localparam int unsigned DATA_W = DefaultDataW;
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned ID_W   = $clog2(N_IN);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [ID_W-1:0]   id;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    axis_pkt_mux_if #(.N_IN(N_IN), .DATA_W(DATA_W)) bus ();

    axis_pkt_mux #(.N_IN(N_IN), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    int    passed = 0;
    int    total = 0;
    int    cyc = 0;
    int    tready_mode = 0;
    beat_t exp_q[$];
    beat_t pend[$];
    int    grant_ids[$];
    beat_t obs_q[$];
    int    obs_cyc[$];
    int    in_cnt = 0, out_cnt = 0, max_occ = 0, full_rdy_viol = 0, stable_viol = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready: 0 = always, 1 = repeating 1,0,0,1, 2 = random.
    initial begin
        int phase;
        phase = 0;
        bus.m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            phase++;
            case (tready_mode)
                1:       bus.m_tready = ((phase % 4) == 0) || ((phase % 4) == 3);
                2:       bus.m_tready = 1'($urandom_range(0, 1));
                default: bus.m_tready = 1'b1;
            endcase
        end
    end

    // Monitor: records delivered beats and tracks buffer occupancy from handshake counts.
    initial begin
        beat_t cur, prev_beat;
        logic  prev_stall;
        int    occ;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_cnt     = 0;
                out_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                cur.data = bus.m_tdata;
                cur.keep = bus.m_tkeep;
                cur.last = bus.m_tlast;
                cur.id   = bus.m_tid;
                if (prev_stall && (cur !== prev_beat)) stable_viol++;
                prev_stall = bus.m_tvalid && !bus.m_tready;
                prev_beat  = cur;
                if (bus.m_tvalid && bus.m_tready) begin
                    obs_q.push_back(cur);
                    obs_cyc.push_back(cyc);
                end
                occ = in_cnt - out_cnt;
                if (occ > max_occ) max_occ = occ;
                if (occ >= 2 && bus.s_tready !== '0) full_rdy_viol++;
                if ((bus.s_tvalid & bus.s_tready) != '0) in_cnt++;
                if (bus.m_tvalid && bus.m_tready) out_cnt++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic add_packet(input int port, input int len);
        grant_ids.push_back(port);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data = $urandom;
            b.keep = KEEP_W'($urandom_range(1, (1 << KEEP_W) - 1));
            b.last = (i == len - 1);
            b.id   = ID_W'(port);
            pend.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_grants();
        while (grant_ids.size() > 0) begin
            int id;
            bit acc;
            int budget;
            id  = grant_ids.pop_front();
            acc = 1'b0;
            budget = 0;
            bus.gnt     = '0;
            bus.gnt[id] = 1'b1;
            bus.gnt_id  = ID_W'(id);
            bus.gnt_vld = 1'b1;
            while (!acc && budget < 500) begin
                @(negedge clk);
                acc = bus.gnt_rdy;
                @(posedge clk);
                #1;
                budget++;
            end
            bus.gnt_vld = 1'b0;
            bus.gnt     = '0;
            if (!acc) begin
                total++;
                $display("FAIL grant_timeout port %0d: accepted=0 required=1", id);
                grant_ids.delete();
            end
        end
    endtask

    task automatic drive_beats(input bit gaps);
        while (pend.size() > 0) begin
            beat_t b;
            bit    fired;
            int    budget;
            b = pend.pop_front();
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            bus.s_tdata[b.id]  = b.data;
            bus.s_tkeep[b.id]  = b.keep;
            bus.s_tlast[b.id]  = b.last;
            bus.s_tvalid[b.id] = 1'b1;
            fired  = 1'b0;
            budget = 0;
            while (!fired && budget < 500) begin
                @(negedge clk);
                fired = bus.s_tready[b.id];
                @(posedge clk);
                #1;
                budget++;
            end
            bus.s_tvalid[b.id] = 1'b0;
            if (!fired) begin
                total++;
                $display("FAIL beat_timeout port %0d: s_tready=0 required=1", b.id);
                pend.delete();
            end
        end
    endtask

    task automatic run_traffic(input bit gaps);
        fork
            drive_grants();
            drive_beats(gaps);
        join
    endtask

    task automatic wait_drain(input int ob);
        int budget;
        budget = 0;
        while ((obs_q.size() - ob) < exp_q.size() && budget < 1000) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({bus.m_tvalid, bus.m_tlast, busy} !== 3'b000 || bus.m_tdata !== '0 ||
            bus.m_tkeep !== '0 || bus.m_tid !== '0 || bus.s_tready !== '0 || bus.gnt_rdy !== 1'b1)
            $display("FAIL reset_values: m_tvalid=%b m_tdata=%h m_tkeep=%h m_tlast=%b m_tid=%0d s_tready=%b gnt_rdy=%b busy=%b, required zeros with gnt_rdy=1",
                     bus.m_tvalid, bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.m_tid,
                     bus.s_tready, bus.gnt_rdy, busy);
        else passed++;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.gnt_rdy !== 1'b1 || bus.m_tvalid !== 1'b0 || bus.s_tready !== '0 || busy !== 1'b0)
                $display("FAIL idle_cycle%0d: gnt_rdy=%b m_tvalid=%b s_tready=%b busy=%b, required 1 0 0 0",
                         i, bus.gnt_rdy, bus.m_tvalid, bus.s_tready, busy);
            else passed++;
        end
    endtask

    task automatic test_single_port();
        int ob;
        logic [N_IN-1:0] rdy_exp;
        ob = obs_q.size();
        exp_q.delete();
        tready_mode = 0;
        @(posedge clk);
        #1;
        add_packet(3, 4);
        drive_grants();
        rdy_exp = '0;
        rdy_exp[3] = 1'b1;
        total++;
        if (bus.s_tready !== rdy_exp || bus.gnt_rdy !== 1'b0 || busy !== 1'b1)
            $display("FAIL lock_after_grant: s_tready=%b gnt_rdy=%b busy=%b, required %b 0 1",
                     bus.s_tready, bus.gnt_rdy, busy, rdy_exp);
        else passed++;
        drive_beats(1'b0);
        total++;
        if (bus.gnt_rdy !== 1'b1 || busy !== 1'b0 || bus.s_tready !== '0)
            $display("FAIL release_after_last: gnt_rdy=%b busy=%b s_tready=%b, required 1 0 0",
                     bus.gnt_rdy, busy, bus.s_tready);
        else passed++;
        wait_drain(ob);
        total++;
        if ((obs_q.size() - ob) !== exp_q.size())
            $display("FAIL single_count: got %0d beats, required %0d", obs_q.size() - ob, exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && (ob + i) < obs_q.size(); i++) begin
            total++;
            if (obs_q[ob + i] !== exp_q[i])
                $display("FAIL single_beat%0d: got %h, required %h", i, obs_q[ob + i], exp_q[i]);
            else passed++;
        end
        if ((obs_q.size() - ob) >= 4) begin
            total++;
            if (obs_cyc[ob + 3] - obs_cyc[ob] !== 3)
                $display("FAIL single_throughput: span %0d cycles, required 3", obs_cyc[ob + 3] - obs_cyc[ob]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int ob;
        int n;
        ob = obs_q.size();
        exp_q.delete();
        tready_mode = 0;
        add_packet(0, 2);
        add_packet(1, 2);
        add_packet(2, 2);
        run_traffic(1'b0);
        wait_drain(ob);
        total++;
        if ((obs_q.size() - ob) !== exp_q.size())
            $display("FAIL b2b_count: got %0d beats, required %0d", obs_q.size() - ob, exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && (ob + i) < obs_q.size(); i++) begin
            total++;
            if (obs_q[ob + i] !== exp_q[i])
                $display("FAIL b2b_beat%0d: got %h, required %h", i, obs_q[ob + i], exp_q[i]);
            else passed++;
        end
        n = obs_q.size() - ob;
        if (n > 6) n = 6;
        for (int i = 0; i + 1 < n; i++) begin
            int gap_exp;
            gap_exp = (i % 2 == 1) ? 2 : 1;
            total++;
            if (obs_cyc[ob + i + 1] - obs_cyc[ob + i] !== gap_exp)
                $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d",
                         i, obs_cyc[ob + i + 1] - obs_cyc[ob + i], gap_exp);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int ob, sv0, fv0;
        ob  = obs_q.size();
        sv0 = stable_viol;
        fv0 = full_rdy_viol;
        exp_q.delete();
        tready_mode = 1;
        add_packet(5, 8);
        run_traffic(1'b0);
        wait_drain(ob);
        tready_mode = 0;
        total++;
        if ((obs_q.size() - ob) !== exp_q.size())
            $display("FAIL bp_count: got %0d beats, required %0d", obs_q.size() - ob, exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && (ob + i) < obs_q.size(); i++) begin
            total++;
            if (obs_q[ob + i] !== exp_q[i])
                $display("FAIL bp_beat%0d: got %h, required %h", i, obs_q[ob + i], exp_q[i]);
            else passed++;
        end
        total++;
        if (stable_viol - sv0 !== 0)
            $display("FAIL bp_stable: %0d changes while stalled, required 0", stable_viol - sv0);
        else passed++;
        total++;
        if (full_rdy_viol - fv0 !== 0)
            $display("FAIL bp_ready_when_full: %0d cycles, required 0", full_rdy_viol - fv0);
        else passed++;
        total++;
        if (max_occ !== 2)
            $display("FAIL bp_occupancy: max %0d beats buffered, required 2", max_occ);
        else passed++;
    endtask

    task automatic test_single_beat();
        int ob;
        ob = obs_q.size();
        exp_q.delete();
        tready_mode = 0;
        for (int k = 0; k < 4; k++) add_packet(7, 1);
        run_traffic(1'b0);
        wait_drain(ob);
        total++;
        if ((obs_q.size() - ob) !== 4)
            $display("FAIL sb_count: got %0d beats, required 4", obs_q.size() - ob);
        else passed++;
        for (int i = 0; i < exp_q.size() && (ob + i) < obs_q.size(); i++) begin
            total++;
            if (obs_q[ob + i] !== exp_q[i])
                $display("FAIL sb_beat%0d: got %h, required %h", i, obs_q[ob + i], exp_q[i]);
            else passed++;
        end
        total++;
        if (busy !== 1'b0 || bus.gnt_rdy !== 1'b1)
            $display("FAIL sb_idle: busy=%b gnt_rdy=%b, required 0 1", busy, bus.gnt_rdy);
        else passed++;
    endtask

    task automatic test_reset_mid_packet();
        int ob;
        ob = obs_q.size();
        exp_q.delete();
        tready_mode = 0;
        grant_ids.push_back(2);
        drive_grants();
        bus.s_tdata[2]  = 32'hA1A1_0001;
        bus.s_tkeep[2]  = '1;
        bus.s_tlast[2]  = 1'b0;
        bus.s_tvalid[2] = 1'b1;
        @(negedge clk);
        total++;
        if (bus.s_tready[2] !== 1'b1)
            $display("FAIL rst_pre_ready: s_tready[2]=%b, required 1", bus.s_tready[2]);
        else passed++;
        @(posedge clk);
        #1;
        bus.s_tdata[2] = 32'hA1A1_0002;
        #2;
        total++;
        if (bus.m_tvalid !== 1'b1)
            $display("FAIL rst_pre_valid: m_tvalid=%b, required 1", bus.m_tvalid);
        else passed++;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.m_tvalid !== 1'b0 || bus.s_tready !== '0 || busy !== 1'b0 ||
            bus.gnt_rdy !== 1'b1 || bus.m_tdata !== '0 || bus.m_tlast !== 1'b0)
            $display("FAIL rst_immediate: m_tvalid=%b s_tready=%b busy=%b gnt_rdy=%b m_tdata=%h m_tlast=%b, required 0 0 0 1 0 0",
                     bus.m_tvalid, bus.s_tready, busy, bus.gnt_rdy, bus.m_tdata, bus.m_tlast);
        else passed++;
        bus.s_tvalid = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        total++;
        if (obs_q.size() - ob !== 0)
            $display("FAIL rst_truncated: %0d beats emitted, required 0", obs_q.size() - ob);
        else passed++;
        ob = obs_q.size();
        @(posedge clk);
        #1;
        add_packet(2, 3);
        run_traffic(1'b0);
        wait_drain(ob);
        total++;
        if ((obs_q.size() - ob) !== exp_q.size())
            $display("FAIL rst_after_count: got %0d beats, required %0d", obs_q.size() - ob, exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && (ob + i) < obs_q.size(); i++) begin
            total++;
            if (obs_q[ob + i] !== exp_q[i])
                $display("FAIL rst_after_beat%0d: got %h, required %h", i, obs_q[ob + i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int ob, sv0, fv0;
        ob  = obs_q.size();
        sv0 = stable_viol;
        fv0 = full_rdy_viol;
        exp_q.delete();
        tready_mode = 2;
        for (int k = 0; k < 12; k++) add_packet(int'($urandom_range(0, N_IN - 1)), int'($urandom_range(1, 6)));
        run_traffic(1'b1);
        wait_drain(ob);
        tready_mode = 0;
        total++;
        if ((obs_q.size() - ob) !== exp_q.size())
            $display("FAIL rand_count: got %0d beats, required %0d", obs_q.size() - ob, exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && (ob + i) < obs_q.size(); i++) begin
            total++;
            if (obs_q[ob + i] !== exp_q[i])
                $display("FAIL rand_beat%0d: got %h, required %h", i, obs_q[ob + i], exp_q[i]);
            else passed++;
        end
        total++;
        if ((stable_viol - sv0) !== 0 || (full_rdy_viol - fv0) !== 0)
            $display("FAIL rand_flow: stall changes %0d, ready-when-full %0d, required 0 0",
                     stable_viol - sv0, full_rdy_viol - fv0);
        else passed++;
    endtask

    initial begin
        bus.gnt      = '0;
        bus.gnt_id   = '0;
        bus.gnt_vld  = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.s_tlast  = '0;
        bus.s_tvalid = '0;
        test_reset();
        test_single_port();
        test_back_to_back();
        test_backpressure();
        test_single_beat();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
